// File: rtl/tick_packet_sender_if.sv
// rtl/tick_packet_sender_if.sv - handshake and status bundle for the tick packet sender
interface tick_packet_sender_if #(
  parameter int PACKET_WIDTH = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 8
);
  localparam int CH_W  = $clog2(NUM_CHANNELS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                             tick;
  logic [NUM_CHANNELS-1:0]              in_empty;
  logic [NUM_CHANNELS*PACKET_WIDTH-1:0] packet_in;
  logic [NUM_CHANNELS-1:0]              ren;
  logic [PACKET_WIDTH-1:0]              packet_out;
  logic                                 packet_out_valid;
  logic [CH_W-1:0]                      packet_out_channel;
  logic                                 out_ready;
  logic [CNT_W-1:0]                     fifo_count;
  logic                                 tick_overrun;

  // Sender side: consumes input buffers, produces the output stream.
  modport master (
    input  tick, in_empty, packet_in, out_ready,
    output ren, packet_out, packet_out_valid, packet_out_channel, fifo_count, tick_overrun
  );

  // Environment side: owns the input buffers and the downstream sink.
  modport slave (
    output tick, in_empty, packet_in, out_ready,
    input  ren, packet_out, packet_out_valid, packet_out_channel, fifo_count, tick_overrun
  );
endinterface

// File: rtl/tick_packet_sender.sv
// rtl/tick_packet_sender.sv - tick-windowed round-robin drain of input buffers into an output FIFO
module tick_packet_sender #(
  parameter int PACKET_WIDTH = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_PER_TICK = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tick_packet_sender_if.master bus
);
  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int WCW  = $clog2(MAX_PER_TICK + 1);
  localparam int EW   = CH_W + PACKET_WIDTH;

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WCW-1:0]    win_cnt_q, win_cnt_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic              overrun_q;

  logic              found;
  logic [CH_W-1:0]   winner;
  logic [CH_W-1:0]   winner_next;
  logic              grant;
  logic              full;
  logic              pop;
  logic [NUM_CHANNELS-1:0] ren_vec;
  logic [PACKET_WIDTH-1:0] win_data;
  logic [EW-1:0]     head;

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = (count_q != '0) && bus.out_ready;

  // Round-robin search: first non-empty channel at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned     sum;
    logic [CH_W-1:0] idx;
    found = 1'b0;
    winner = '0;
    sum = 0;
    idx = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sum = (32'(rr_ptr_q) + 32'(i)) % NUM_CHANNELS;
      idx = CH_W'(sum);
      if (!found && !bus.in_empty[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign winner_next = (winner == CH_W'(NUM_CHANNELS - 1)) ? '0 : winner + 1'b1;
  assign win_data    = bus.packet_in[32'(winner)*PACKET_WIDTH +: PACKET_WIDTH];

  // Next-state: window opens on tick, closes when inputs run dry or the quota is used.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_cnt_d = win_cnt_q;
    grant     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tick) begin
          state_d   = DRAIN;
          win_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (!found) begin
          state_d = IDLE;
        end else if (!full) begin
          grant     = 1'b1;
          rr_ptr_d  = winner_next;
          win_cnt_d = win_cnt_q + 1'b1;
          if (win_cnt_q == WCW'(MAX_PER_TICK - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot read strobe for the granted channel.
  always_comb begin
    ren_vec = '0;
    if (grant) ren_vec[winner] = 1'b1;
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state, FIFO pointers and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      win_cnt_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_cnt_q <= win_cnt_d;
      count_q   <= count_d;
      if (grant) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (bus.tick && state_q == DRAIN) overrun_q <= 1'b1;
    end
  end

  // FIFO storage holds {channel, word}; contents are don't-care once pointers reset.
  always_ff @(posedge clk) begin
    if (grant) mem_q[wr_ptr_q] <= {winner, win_data};
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.ren                = ren_vec;
  assign bus.packet_out_valid   = (count_q != '0);
  assign bus.packet_out         = bus.packet_out_valid ? head[PACKET_WIDTH-1:0] : '0;
  assign bus.packet_out_channel = bus.packet_out_valid ? head[EW-1 -: CH_W] : '0;
  assign bus.fifo_count         = count_q;
  assign bus.tick_overrun       = overrun_q;
endmodule
